// File: rtl/vx_fp_div_arb.sv
// Shares one pipelined FP divider among NUM_REQS requesters. Grants are round-robin, issue goes through a single
// register, and responses are routed back by the requester id carried in the divider tag.

module vx_fp_div_arb_slot #(
  parameter int IDW = 1,
  parameter int ID  = 0
) (
  input  logic [IDW-1:0] grant_id,
  input  logic           grant_vld,
  input  logic           can_load,
  input  logic           rsp_vld,
  input  logic [IDW-1:0] rsp_id,
  output logic           req_ready,
  output logic           rsp_valid
);
  localparam logic [IDW-1:0] MY_ID = IDW'(ID);

  assign req_ready = can_load && grant_vld && (grant_id == MY_ID);
  assign rsp_valid = rsp_vld && (rsp_id == MY_ID);
endmodule

module vx_fp_div_arb #(
  parameter int NUM_REQS      = 4,
  parameter int LANES         = 1,
  parameter int TAGW          = 1,
  parameter int MAX_INFL      = 8,
  parameter int INST_FRM_BITS = 3,
  localparam int IDW          = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int DTAGW        = IDW + TAGW
) (
  input  logic                                   clk,
  input  logic                                   reset,

  input  logic [NUM_REQS-1:0]                    req_valid,
  output logic [NUM_REQS-1:0]                    req_ready,
  input  logic [NUM_REQS-1:0][TAGW-1:0]          req_tag,
  input  logic [NUM_REQS-1:0][INST_FRM_BITS-1:0] req_frm,
  input  logic [NUM_REQS-1:0][LANES-1:0][31:0]   req_dataa,
  input  logic [NUM_REQS-1:0][LANES-1:0][31:0]   req_datab,

  output logic [NUM_REQS-1:0]                    rsp_valid,
  input  logic [NUM_REQS-1:0]                    rsp_ready,
  output logic [TAGW-1:0]                        rsp_tag,
  output logic [LANES-1:0][31:0]                 rsp_result,

  output logic                                   div_valid_in,
  input  logic                                   div_ready_in,
  output logic [DTAGW-1:0]                       div_tag_in,
  output logic [INST_FRM_BITS-1:0]               div_frm,
  output logic [LANES-1:0][31:0]                 div_dataa,
  output logic [LANES-1:0][31:0]                 div_datab,
  input  logic [LANES-1:0][31:0]                 div_result,
  input  logic [DTAGW-1:0]                       div_tag_out,
  input  logic                                   div_valid_out,
  output logic                                   div_ready_out
);
  localparam int              CNTW     = $clog2(MAX_INFL) + 1;
  localparam logic [CNTW-1:0] INFL_MAX = CNTW'(MAX_INFL);
  localparam logic [IDW:0]    NREQ     = (IDW+1)'(NUM_REQS);
  localparam logic [IDW-1:0]  LAST_ID  = IDW'(NUM_REQS - 1);

  logic                     iss_valid;
  logic [IDW-1:0]           iss_id;
  logic [TAGW-1:0]          iss_tag;
  logic [INST_FRM_BITS-1:0] iss_frm;
  logic [LANES-1:0][31:0]   iss_dataa;
  logic [LANES-1:0][31:0]   iss_datab;

  logic [IDW-1:0]  ptr;
  logic [CNTW-1:0] infl;
  logic [CNTW-1:0] infl_after;

  logic [IDW-1:0]  grant_id;
  logic            grant_vld;
  logic [IDW:0]    cand_sum;
  logic [IDW-1:0]  cand;
  logic            can_load;
  logic            accept;
  logic            issue_fire;
  logic            rsp_fire;
  logic [IDW-1:0]  rsp_id;
  logic            rsp_id_ok;

  // Round-robin search starting at ptr; ptr and k are both below NUM_REQS, so one subtract wraps the sum.
  always_comb begin
    grant_id  = ptr;
    grant_vld = 1'b0;
    cand_sum  = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      cand_sum = {1'b0, ptr} + (IDW+1)'(k);
      if (cand_sum >= NREQ) cand_sum = cand_sum - NREQ;
      cand = cand_sum[IDW-1:0];
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
  end

  assign issue_fire = div_valid_in && div_ready_in;
  assign rsp_fire   = div_valid_out && div_ready_out;
  assign infl_after = infl - CNTW'(rsp_fire);
  // A response retiring this cycle frees its slot for an accept in the same cycle.
  assign can_load   = reset && (!iss_valid || issue_fire) && (infl_after < INFL_MAX);
  assign accept     = |(req_valid & req_ready);

  assign rsp_id    = div_tag_out[DTAGW-1:TAGW];
  assign rsp_id_ok = ({1'b0, rsp_id} < NREQ);

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_slot
    vx_fp_div_arb_slot #(.IDW(IDW), .ID(i)) u_slot (
      .grant_id  (grant_id),
      .grant_vld (grant_vld),
      .can_load  (can_load),
      .rsp_vld   (div_valid_out),
      .rsp_id    (rsp_id),
      .req_ready (req_ready[i]),
      .rsp_valid (rsp_valid[i])
    );
  end

  // Responses with an out-of-range id have no owner and are drained rather than wedging the divider.
  assign div_ready_out = !div_valid_out || !rsp_id_ok || |(rsp_valid & rsp_ready);
  assign rsp_tag       = div_tag_out[TAGW-1:0];
  assign rsp_result    = div_result;

  assign div_valid_in = iss_valid && reset;
  assign div_tag_in   = {iss_id, iss_tag};
  assign div_frm      = iss_frm;
  assign div_dataa    = iss_dataa;
  assign div_datab    = iss_datab;

  always_ff @(posedge clk) begin
    if (!reset) begin
      iss_valid <= 1'b0;
      ptr       <= '0;
      infl      <= '0;
    end else begin
      if (accept) begin
        iss_valid <= 1'b1;
        ptr       <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
      end else if (issue_fire) begin
        iss_valid <= 1'b0;
      end
      case ({accept, rsp_fire})
        2'b10:   infl <= infl + 1'b1;
        2'b01:   infl <= infl - 1'b1;
        default: infl <= infl;
      endcase
    end
  end

  // Payload is not reset; it only matters once iss_valid is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      iss_id    <= grant_id;
      iss_tag   <= req_tag[grant_id];
      iss_frm   <= req_frm[grant_id];
      iss_dataa <= req_dataa[grant_id];
      iss_datab <= req_datab[grant_id];
    end
  end
endmodule

// File: tb/tb_vx_fp_div_arb.sv
// Directed bench for vx_fp_div_arb with a queued divider stand-in and a response scoreboard.
// The stand-in computes a - b + 1.0 on the raw bits, which is exact division for power-of-two operands.

module tb_vx_fp_div_arb;
  localparam int N = 4, L = 1, TW = 2, MI = 8, FB = 3, IDW = 2, DTW = IDW + TW, LAT = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]                req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N-1:0][TW-1:0]        req_tag;
  logic [N-1:0][FB-1:0]        req_frm;
  logic [N-1:0][L-1:0][31:0]   req_dataa, req_datab;
  logic [TW-1:0]               rsp_tag;
  logic [L-1:0][31:0]          rsp_result;
  logic                        div_valid_in, div_ready_in, div_ready_out;
  logic [DTW-1:0]              div_tag_in;
  logic [FB-1:0]               div_frm;
  logic [L-1:0][31:0]          div_dataa, div_datab;
  logic [L-1:0][31:0]          div_result  = '0;
  logic [DTW-1:0]              div_tag_out = '0;
  logic                        div_valid_out = 1'b0;

  vx_fp_div_arb #(.NUM_REQS(N), .LANES(L), .TAGW(TW), .MAX_INFL(MI), .INST_FRM_BITS(FB)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag), .req_frm(req_frm),
    .req_dataa(req_dataa), .req_datab(req_datab),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_result(rsp_result),
    .div_valid_in(div_valid_in), .div_ready_in(div_ready_in), .div_tag_in(div_tag_in), .div_frm(div_frm),
    .div_dataa(div_dataa), .div_datab(div_datab), .div_result(div_result), .div_tag_out(div_tag_out),
    .div_valid_out(div_valid_out), .div_ready_out(div_ready_out)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string t, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask

  // Divider stand-in: in-order queue with fixed latency, holds its head while div_ready_out=0.
  typedef struct packed { logic [31:0] due; logic [DTW-1:0] tag; logic [31:0] res; } dent_t;
  dent_t dq[$];
  int unsigned cyc = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!reset) begin
      dq.delete();
      div_valid_out <= 1'b0;
    end else begin
      if (div_valid_out && div_ready_out) void'(dq.pop_front());
      if (div_valid_in && div_ready_in)
        dq.push_back('{cyc + LAT, div_tag_in, div_dataa[0] - div_datab[0] + 32'h3F80_0000});
      if (dq.size() > 0 && dq[0].due <= cyc) begin
        div_valid_out <= 1'b1;
        div_tag_out   <= dq[0].tag;
        div_result[0] <= dq[0].res;
      end else begin
        div_valid_out <= 1'b0;
      end
    end
  end

  // Scoreboard: expected entries pushed at accept, popped at response fire.
  typedef struct packed { logic [IDW-1:0] id; logic [TW-1:0] tag; logic [31:0] res; } exp_t;
  exp_t sb[$];
  int   acc_ids[$];
  int   acc_cnt = 0;
  exp_t e;

  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
    end else begin
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back('{IDW'(i), req_tag[i], req_dataa[i][0] - req_datab[i][0] + 32'h3F80_0000});
          acc_ids.push_back(i);
          acc_cnt++;
        end
      for (int i = 0; i < N; i++)
        if (rsp_valid[i] && rsp_ready[i]) begin
          if (sb.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
          else begin
            e = sb.pop_front();
            chk("rsp_id", 64'(i), 64'(e.id));
            chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
            chk("rsp_result", 64'(rsp_result), 64'(e.res));
          end
        end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    req_valid = '0; rsp_ready = '1; div_ready_in = 1'b1;
    repeat (20) step();
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  int  exp_order[5] = '{0, 1, 2, 3, 0};
  bit  found;

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; req_valid = '0; rsp_ready = '1; div_ready_in = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_tag[i]      = TW'(i);
      req_frm[i]      = FB'(i);
      req_dataa[i][0] = 32'h4000_0000 + (32'(i) << 23);
      req_datab[i][0] = 32'h3F80_0000;
    end
    repeat (2) step();

    // Held in reset with every requester asking
    req_valid = '1;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_div_valid_in", 64'(div_valid_in), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    step();
    reset = 1'b1;

    // All requesters busy: grants rotate 0,1,2,3,0 at one per cycle
    @(negedge clk);
    chk("rr_first_ready", 64'(req_ready), 64'b0001);
    chk("rr_no_issue_yet", 64'(div_valid_in), 64'd0);
    for (int c = 0; c < 5; c++) begin
      step();
      if (c == 4) req_valid = '0;
      chk("rr_div_valid_in", 64'(div_valid_in), 64'd1);
    end
    chk("rr_accept_count", 64'(acc_ids.size()), 64'd5);
    for (int k = 0; k < 5; k++)
      if (k < acc_ids.size()) chk("rr_order", 64'(acc_ids[k]), 64'(exp_order[k]));
    drain();

    // Single requester 2: 4.0 / 2.0
    req_tag[2] = 2'd1; req_dataa[2][0] = 32'h4080_0000; req_datab[2][0] = 32'h4000_0000;
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    chk("one_div_valid_in", 64'(div_valid_in), 64'd1);
    chk("one_div_tag_in", 64'(div_tag_in), 64'b1001);
    chk("one_div_dataa", 64'(div_dataa), 64'h4080_0000);
    chk("one_div_datab", 64'(div_datab), 64'h4000_0000);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        found = 1'b1;
        chk("one_rsp_valid", 64'(rsp_valid), 64'b0100);
        chk("one_rsp_result", 64'(rsp_result), 64'h4000_0000);
      end
    end
    chk("one_rsp_seen", 64'(found), 64'd1);
    step();
    drain();

    // In-flight cap: responses held, exactly MAX_INFL accepts (grants start at 3)
    acc_cnt = 0; rsp_ready = '0; req_valid = '1;
    repeat (12) step();
    @(negedge clk);
    chk("cap_accepts", 64'(acc_cnt), 64'd8);
    chk("cap_ready_low", 64'(req_ready), 64'd0);
    chk("cap_head_present", 64'(div_valid_out), 64'd1);
    step();
    rsp_ready = '1;
    @(negedge clk);
    chk("cap_rsp_fire", 64'(div_ready_out), 64'd1);
    chk("cap_ready_on_fire", 64'(req_ready), 64'b1000);
    step();
    rsp_ready = '0;
    @(negedge clk);
    chk("cap_ready_low2", 64'(req_ready), 64'd0);
    chk("cap_accepts2", 64'(acc_cnt), 64'd9);
    step();
    drain();

    // Divider stall for 3 cycles holds the issue register
    req_tag[0] = 2'd2; req_dataa[0][0] = 32'h4100_0000; req_datab[0][0] = 32'h3F80_0000;
    req_valid = 4'b0001; div_ready_in = 1'b0;
    step();
    req_tag[0] = 2'd3; req_dataa[0][0] = 32'h4180_0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_div_valid_in", 64'(div_valid_in), 64'd1);
      chk("stall_div_dataa", 64'(div_dataa), 64'h4100_0000);
      chk("stall_div_tag_in", 64'(div_tag_in), 64'b0010);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
      step();
    end
    div_ready_in = 1'b1;
    @(negedge clk);
    chk("stall_release_ready", 64'(req_ready), 64'b0001);
    step();
    req_valid = '0;
    chk("stall_next_dataa", 64'(div_dataa), 64'h4180_0000);
    chk("stall_next_tag_in", 64'(div_tag_in), 64'b0011);
    drain();

    // Head-of-line: id 1 response blocked, id 0 behind it stays hidden
    rsp_ready = 4'b1101; req_valid = 4'b0011;
    step(); step();
    req_valid = '0;
    repeat (6) step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hol_rsp_valid", 64'(rsp_valid), 64'b0010);
      chk("hol_div_ready_out", 64'(div_ready_out), 64'd0);
      step();
    end
    rsp_ready = '1;
    @(negedge clk);
    chk("hol_release", 64'(div_ready_out), 64'd1);
    step();
    drain();

    // Reset with 5 in flight and ptr away from 0
    acc_cnt = 0; rsp_ready = '0; req_valid = '1;
    repeat (5) step();
    chk("mid_accepts", 64'(acc_cnt), 64'd5);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_div_valid_in", 64'(div_valid_in), 64'd0);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(req_ready), 64'b0001);
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    step();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
